// File: rtl/platform_collision.sv
// Platform collision: scans a writable table of horizontal platforms plus the
// screen floor, one entry per clock, and reports where the player can stand.
module platform_collision #(
    parameter int NUM_PLATFORMS = 8,
    parameter int COORD_W       = 16,
    parameter int PLAYER_SIZE_X = 36,
    parameter int PLAYER_SIZE_Y = 42,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int GROUND_TOL    = 1,
    localparam int AW = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1,
    localparam int HW = $clog2(NUM_PLATFORMS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] playerX,
    input  logic [COORD_W-1:0] playerY,
    input  logic               plat_we,
    input  logic [AW-1:0]      plat_addr,
    input  logic               plat_en,
    input  logic [COORD_W-1:0] plat_x,
    input  logic [COORD_W-1:0] plat_y,
    input  logic [COORD_W-1:0] plat_w,
    output logic               grounded,
    output logic [COORD_W-1:0] groundedY,
    output logic [HW-1:0]      hit_index,
    output logic               wall_left,
    output logic               wall_right,
    output logic               busy,
    output logic               done
);

    localparam int EW = COORD_W + 1;
    localparam logic [EW-1:0]      PSX_E       = EW'(PLAYER_SIZE_X);
    localparam logic [EW-1:0]      PSY_E       = EW'(PLAYER_SIZE_Y);
    localparam logic [EW-1:0]      TOL_E       = EW'(GROUND_TOL);
    localparam logic [EW-1:0]      FLOOR_MIN_E = EW'(SCREEN_H - 1);
    localparam logic [EW-1:0]      WALL_R_E    = EW'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] FLOOR_SURF  = COORD_W'(SCREEN_H);
    localparam logic [COORD_W-1:0] PSY_C       = COORD_W'(PLAYER_SIZE_Y);
    localparam logic [HW-1:0]      LAST_IDX    = HW'(NUM_PLATFORMS - 1);
    localparam logic [HW-1:0]      FLOOR_IDX   = HW'(NUM_PLATFORMS);

    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

    state_t state_reg, state_next;

    logic [COORD_W-1:0] px_reg, py_reg;
    logic [HW-1:0]      idx_reg;
    logic               best_valid_reg;
    logic [COORD_W-1:0] best_surf_reg;
    logic [HW-1:0]      best_idx_reg;

    logic               grounded_reg, wall_left_reg, wall_right_reg, done_reg;
    logic [COORD_W-1:0] grounded_y_reg;
    logic [HW-1:0]      hit_index_reg;

    // All comparisons run one bit wider than the coordinates so nothing wraps.
    logic [EW-1:0] pl_left, pl_right, feet;
    assign pl_left  = {1'b0, px_reg};
    assign pl_right = pl_left + PSX_E;
    assign feet     = {1'b0, py_reg} + PSY_E;

    logic [NUM_PLATFORMS-1:0]         match_vec;
    logic [NUM_PLATFORMS*COORD_W-1:0] surf_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLATFORMS; gi++) begin : g_entry
            logic               en_reg;
            logic [COORD_W-1:0] x_reg, y_reg, w_reg;
            logic [EW-1:0]      right_e, y_lo, y_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    en_reg <= 1'b0;
                end else if (plat_we && plat_addr == AW'(gi)) begin
                    en_reg <= plat_en;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst && plat_we && plat_addr == AW'(gi)) begin
                    x_reg <= plat_x;
                    y_reg <= plat_y;
                    w_reg <= plat_w;
                end
            end

            assign right_e = {1'b0, x_reg} + {1'b0, w_reg} - EW'(1);
            assign y_lo    = (y_reg == '0) ? '0 : {1'b0, y_reg} - EW'(1);
            assign y_hi    = {1'b0, y_reg} + TOL_E;

            assign match_vec[gi] = en_reg && (w_reg != '0)
                                 && (pl_left <= right_e) && (pl_right >= {1'b0, x_reg})
                                 && (feet >= y_lo) && (feet <= y_hi);
            assign surf_flat[gi*COORD_W +: COORD_W] = y_reg;
        end
    endgenerate

    logic [AW-1:0]      idx_sel;
    logic               cur_match, take_cur;
    logic [COORD_W-1:0] cur_surf;

    assign idx_sel   = idx_reg[AW-1:0];
    assign cur_match = match_vec[idx_sel];
    assign cur_surf  = surf_flat[idx_sel*COORD_W +: COORD_W];
    // Strict compare keeps the earlier (lower) index on equal surfaces.
    assign take_cur  = cur_match && (!best_valid_reg || cur_surf < best_surf_reg);

    logic               floor_match;
    logic               fin_valid;
    logic [COORD_W-1:0] fin_surf;
    logic [HW-1:0]      fin_idx;

    assign floor_match = (feet >= FLOOR_MIN_E);

    // Floor only wins when strictly higher than the best table hit.
    always_comb begin
        fin_valid = best_valid_reg;
        fin_surf  = best_surf_reg;
        fin_idx   = best_idx_reg;
        if (floor_match && (!best_valid_reg || FLOOR_SURF < best_surf_reg)) begin
            fin_valid = 1'b1;
            fin_surf  = FLOOR_SURF;
            fin_idx   = FLOOR_IDX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (idx_reg == LAST_IDX) state_next = RESOLVE;
            RESOLVE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_reg         <= '0;
            py_reg         <= '0;
            idx_reg        <= '0;
            best_valid_reg <= 1'b0;
            best_surf_reg  <= '0;
            best_idx_reg   <= '0;
            grounded_reg   <= 1'b0;
            grounded_y_reg <= '0;
            hit_index_reg  <= '0;
            wall_left_reg  <= 1'b0;
            wall_right_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        px_reg         <= playerX;
                        py_reg         <= playerY;
                        idx_reg        <= '0;
                        best_valid_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    if (take_cur) begin
                        best_valid_reg <= 1'b1;
                        best_surf_reg  <= cur_surf;
                        best_idx_reg   <= idx_reg;
                    end
                    idx_reg <= idx_reg + HW'(1);
                end
                RESOLVE: begin
                    grounded_reg <= fin_valid;
                    if (fin_valid) begin
                        grounded_y_reg <= fin_surf - PSY_C;
                        hit_index_reg  <= fin_idx;
                    end
                    wall_left_reg  <= (px_reg == '0);
                    wall_right_reg <= (pl_right >= WALL_R_E);
                    done_reg       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grounded   = grounded_reg;
    assign groundedY  = grounded_y_reg;
    assign hit_index  = hit_index_reg;
    assign wall_left  = wall_left_reg;
    assign wall_right = wall_right_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_platform_collision.sv
// Self-checking bench for platform_collision: directed cases plus randomized
// table/position traffic checked against a plain arithmetic reference model.
module tb_platform_collision;

    localparam int N   = 8;
    localparam int CW  = 16;
    localparam int PSX = 36;
    localparam int PSY = 42;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int TOL = 1;

    logic          clk = 1'b0;
    logic          rst, start, plat_we, plat_en;
    logic [CW-1:0] playerX, playerY, plat_x, plat_y, plat_w;
    logic [2:0]    plat_addr;
    logic          grounded, wall_left, wall_right, busy, done;
    logic [CW-1:0] groundedY;
    logic [3:0]    hit_index;

    platform_collision dut (
        .clk(clk), .rst(rst), .start(start),
        .playerX(playerX), .playerY(playerY),
        .plat_we(plat_we), .plat_addr(plat_addr), .plat_en(plat_en),
        .plat_x(plat_x), .plat_y(plat_y), .plat_w(plat_w),
        .grounded(grounded), .groundedY(groundedY), .hit_index(hit_index),
        .wall_left(wall_left), .wall_right(wall_right),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference table and expected result state
    int m_en[N], m_x[N], m_y[N], m_w[N];
    int m_gnd, m_gy, m_hit, m_wl, m_wr;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lowest surface y among all standable surfaces; ties go to the first found.
    task automatic model_eval(input int px, input int py);
        int feet, best, bi, found, lo;
        feet  = py + PSY;
        found = 0;
        best  = 0;
        bi    = 0;
        for (int i = 0; i < N; i++) begin
            lo = (m_y[i] == 0) ? 0 : m_y[i] - 1;
            if (m_en[i] != 0 && m_w[i] != 0 &&
                px <= m_x[i] + m_w[i] - 1 && px + PSX >= m_x[i] &&
                feet >= lo && feet <= m_y[i] + TOL) begin
                if (found == 0 || m_y[i] < best) begin
                    found = 1;
                    best  = m_y[i];
                    bi    = i;
                end
            end
        end
        if (feet >= SH - 1 && (found == 0 || SH < best)) begin
            found = 1;
            best  = SH;
            bi    = N;
        end
        m_gnd = found;
        if (found != 0) begin
            m_gy  = (best - PSY) & 16'hFFFF;
            m_hit = bi;
        end
        m_wl = (px == 0) ? 1 : 0;
        m_wr = (px + PSX >= SW - 1) ? 1 : 0;
    endtask

    task automatic write_plat(input int a, input int en, input int x, input int y, input int w);
        plat_addr = 3'(a);
        plat_en   = en[0];
        plat_x    = CW'(x);
        plat_y    = CW'(y);
        plat_w    = CW'(w);
        plat_we   = 1'b1;
        @(posedge clk); #1;
        plat_we   = 1'b0;
        m_en[a] = en; m_x[a] = x; m_y[a] = y; m_w[a] = w;
        $display("write  entry=%0d en=%0d x=%0d y=%0d w=%0d", a, en, x, y, w);
    endtask

    // extra=1 pulses a second start (different position) mid-scan; it must be ignored.
    task automatic do_scan(input string tag, input int px, input int py, input bit extra);
        int cyc;
        playerX = CW'(px);
        playerY = CW'(py);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, ".busy_start"}, int'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            start = extra && (cyc == 2);
            if (start) playerX = CW'(px + 50);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_val({tag, ".latency"}, cyc, N + 1);
        check_val({tag, ".busy_end"}, int'(busy), 0);
        model_eval(px, py);
        check_val({tag, ".grounded"}, int'(grounded), m_gnd);
        check_val({tag, ".groundedY"}, int'(groundedY), m_gy);
        check_val({tag, ".hit_index"}, int'(hit_index), m_hit);
        check_val({tag, ".wall_left"}, int'(wall_left), m_wl);
        check_val({tag, ".wall_right"}, int'(wall_right), m_wr);
        $display("scan   %s px=%0d py=%0d -> gnd=%0d gy=%0d hit=%0d wl=%0d wr=%0d",
                 tag, px, py, grounded, groundedY, hit_index, wall_left, wall_right);
        @(posedge clk); #1;
        check_val({tag, ".done_pulse"}, int'(done), 0);
        check_val({tag, ".idle_after"}, int'(busy), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".grounded"}, int'(grounded), 0);
        check_val({tag, ".groundedY"}, int'(groundedY), 0);
        check_val({tag, ".hit_index"}, int'(hit_index), 0);
        check_val({tag, ".wall_left"}, int'(wall_left), 0);
        check_val({tag, ".wall_right"}, int'(wall_right), 0);
        check_val({tag, ".busy"}, int'(busy), 0);
        check_val({tag, ".done"}, int'(done), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_en[i] = 0;
        m_gnd = 0; m_gy = 0; m_hit = 0; m_wl = 0; m_wr = 0;
    endtask

    initial begin
        int a, px, py, j;
        rst = 1'b1; start = 1'b0; plat_we = 1'b0; plat_en = 1'b0;
        playerX = '0; playerY = '0; plat_addr = '0;
        plat_x = '0; plat_y = '0; plat_w = '0;
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_w[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Floor only
        do_scan("floor", 300, 437, 1'b0);

        // Single platform: hit, no overlap (hold), zero width
        write_plat(2, 1, 100, 300, 80);
        do_scan("plat2", 120, 258, 1'b0);
        do_scan("no_overlap", 181, 258, 1'b0);
        do_scan("edge_overlap", 179, 258, 1'b0);
        write_plat(2, 1, 100, 300, 0);
        do_scan("zero_w", 120, 258, 1'b0);

        // Tie on equal surfaces, then higher surface beats lower index
        write_plat(1, 1, 100, 300, 80);
        write_plat(5, 1, 100, 300, 80);
        do_scan("tie", 120, 258, 1'b0);
        do_scan("tol_below", 120, 259, 1'b0);
        do_scan("tol_above", 120, 257, 1'b0);
        do_scan("tol_out", 120, 260, 1'b0);
        write_plat(3, 1, 100, 200, 80);
        do_scan("plat_y200", 120, 159, 1'b0);
        write_plat(0, 1, 100, 201, 80);
        write_plat(6, 1, 100, 200, 80);
        do_scan("higher_wins", 120, 158, 1'b0);

        // Table entry at floor level wins the tie against the floor
        write_plat(4, 1, 200, 480, 100);
        do_scan("floor_tie", 220, 438, 1'b0);

        // Walls
        do_scan("wall_l", 0, 437, 1'b0);
        do_scan("wall_r603", 603, 437, 1'b0);
        do_scan("wall_r602", 602, 437, 1'b0);

        // Start during busy is ignored
        do_scan("busy_start", 120, 258, 1'b1);

        // Reset mid-scan aborts and clears table
        playerX = CW'(120); playerY = CW'(258); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_reset_state("mid_rst");
        repeat (N + 3) @(posedge clk);
        #1 check_val("mid_rst.no_done", int'(done), 0);
        do_scan("after_rst", 120, 258, 1'b0);
        do_scan("after_rst_floor", 10, 440, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, N - 1);
                write_plat(a, ($urandom_range(0, 5) != 0) ? 1 : 0,
                           $urandom_range(0, 600), $urandom_range(50, 480),
                           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 120));
            end
            j = $urandom_range(0, N - 1);
            case ($urandom_range(0, 3))
                0: begin
                    px = $urandom_range(0, 640);
                    py = $urandom_range(0, 460);
                end
                1: begin
                    px = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(600, 606);
                    py = $urandom_range(434, 442);
                end
                default: begin
                    px = m_x[j] + $urandom_range(0, m_w[j] + 40) - 38;
                    py = m_y[j] - PSY + $urandom_range(0, 4) - 2;
                end
            endcase
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            do_scan("rand", px, py, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/platform_collision.md
Name: platform_collision

Overview:
- Parametrised successor to the single-floor grounded check in the game top level.
- Holds a writable table of NUM_PLATFORMS horizontal platforms plus an implicit screen floor.
- On each game tick, scans the table sequentially, one entry per clk, against the player bounding box.
- Reports grounded / groundedY for character_physics, plus wall contact flags and the index of the supporting platform.

Parameters:
NUM_PLATFORMS, 8, number of table entries (1..64)
COORD_W, 16, width of all coordinates
PLAYER_SIZE_X, 36, player width minus 1
PLAYER_SIZE_Y, 42, player height
SCREEN_W, 640, horizontal resolution
SCREEN_H, 480, vertical resolution; floor surface y
GROUND_TOL, 1, pixels below a surface still counted as standing on it

Ports:
clk  in  1  system clock; sole clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse (game tick) requesting a scan
playerX  in  COORD_W  player left edge
playerY  in  COORD_W  player top edge
plat_we  in  1  table write strobe
plat_addr  in  $clog2(NUM_PLATFORMS)  entry written
plat_en  in  1  entry valid bit
plat_x  in  COORD_W  platform left edge
plat_y  in  COORD_W  platform top surface y
plat_w  in  COORD_W  platform width in pixels (0 = never matches)
grounded  out  1  player stands on a surface
groundedY  out  COORD_W  playerY that rests the player exactly on that surface
hit_index  out  $clog2(NUM_PLATFORMS+1)  supporting entry; NUM_PLATFORMS = floor
wall_left  out  1  playerX == 0
wall_right  out  1  playerX + PLAYER_SIZE_X >= SCREEN_W-1
busy  out  1  scan in progress
done  out  1  one-cycle pulse when results update

Behaviour:
- Reset: IDLE; grounded=0, groundedY=0, hit_index=0, walls=0, busy=0, done=0; all table plat_en cleared. Reset mid-scan aborts the scan with no output update.
- Table writes: registered; take effect the edge after plat_we; accepted in any state, including during a scan. An entry evaluated on the same edge as its write uses the old contents.
- FSM IDLE -> SCAN -> RESOLVE -> IDLE.
  - IDLE: start=1 latches playerX/Y; clears best-hit accumulator; idx=0; -> SCAN.
  - SCAN: one entry per cycle, idx 0..NUM_PLATFORMS-1; after the last entry -> RESOLVE.
  - RESOLVE: evaluates the floor, commits all outputs, pulses done for 1 cycle; -> IDLE.
- Latency: start sampled at edge k -> outputs and done valid after edge k+NUM_PLATFORMS+1.
- busy=1 whenever state != IDLE. start while busy is ignored; no queuing.
- Outputs hold their values between scans.
- Entry i matches when all hold, using COORD_W+1-bit arithmetic with no wrap:
  - plat_en=1 and plat_w != 0
  - horizontal overlap: playerX <= plat_x+plat_w-1 and playerX+PLAYER_SIZE_X >= plat_x
  - feet = playerY+PLAYER_SIZE_Y satisfies plat_y-1 <= feet <= plat_y+GROUND_TOL (plat_y=0: lower bound 0)
- Floor match: feet >= SCREEN_H-1 (no upper bound); surface = SCREEN_H.
- Selection among matches:
  - highest surface (smallest surface y) wins;
  - tie: lower index wins;
  - floor loses ties to table entries.
- On a match: grounded=1, groundedY = surface - PLAYER_SIZE_Y, hit_index = winner.
- No match: grounded=0; groundedY and hit_index keep their previous values.
- Wall flags are computed from the latched player position in RESOLVE.

Test Plan:
- Reset, empty table, playerY=437 (feet 479), start -> after 9 cycles: done=1, grounded=1, groundedY=438, hit_index=8; busy high for exactly 9 cycles.
- Entry 2 = {en, x=100, y=300, w=80}, playerX=120, playerY=258 (feet 300), start -> grounded=1, groundedY=258, hit_index=2.
- Same entry, playerX=181 (no overlap), playerY=258 -> grounded=0; groundedY stays 258, hit_index stays 2. Then set plat_w=0 at playerX=120 -> grounded=0.
- Entries 1 and 5 both at y=300 and overlapping; a second platform at y=200 overlapping with feet=201 -> hit_index=1 for the tie case; the higher surface (y=200) wins when both match.
- Pulse start during busy, then assert rst mid-scan -> second start ignored; after reset all outputs are 0, the table is empty, and a new start runs a full scan.
- playerX=0 -> wall_left=1; playerX=603 -> wall_right=1; playerX=602 -> wall_right=0.
